logic_shift_unit: RTL and testbench

LOGIC_SHIFT_UNIT -- requirements
Module: logic_shift_unit

---
 rtl/logic_shift_unit.sv | 126 ++++++++++++
 tb/tb_logic_shift_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/logic_shift_unit.sv
// Logic/rotate execution unit: single-cycle bitwise ops and a serial one-bit-per-cycle rotator,
// with a valid/ready handshake on both sides and zero/parity flags on the held result.
module logic_shift_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Logic_FUN,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Logic_OUT,
  output logic             Logic_Flag,
  input  logic             Out_Ready,
  output logic             Zero_Flag,
  output logic             Parity_Flag
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    StIdle,
    StRot,
    StHold
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] result;
  logic [SHW-1:0]   rot_n;
  logic             is_rot;
  logic             in_ready;
  logic             accept;
  logic             hold;

  assign rot_n  = B[SHW-1:0];
  assign is_rot = (Logic_FUN[2:1] == 2'b11);

  // Rotates by a non-zero count go through the serial path; a zero-count rotate is A itself.
  always_comb begin
    result = '0;
    case (Logic_FUN)
      3'b000:  result = A & B;
      3'b001:  result = A | B;
      3'b010:  result = ~(A & B);
      3'b011:  result = ~(A | B);
      3'b100:  result = A ^ B;
      3'b101:  result = ~(A ^ B);
      default: result = A;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      StIdle:  in_ready = 1'b1;
      StHold:  in_ready = Out_Ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = In_Valid & in_ready;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;

    case (state_q)
      StRot: begin
        work_d = dir_q ? {work_q[0], work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (Out_Ready && !In_Valid) begin
          state_d = StIdle;
        end
      end
      default: ;
    endcase

    // Acceptance only happens in StIdle/StHold, so it never collides with the StRot update.
    if (accept) begin
      dir_d = Logic_FUN[0];
      if (is_rot && (rot_n != '0)) begin
        state_d = StRot;
        work_d  = A;
        cnt_d   = rot_n;
      end else begin
        state_d = StHold;
        work_d  = result;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign hold        = (state_q == StHold);
  assign In_Ready    = in_ready;
  assign Logic_Flag  = hold;
  assign Logic_OUT   = hold ? work_q : '0;
  assign Zero_Flag   = hold & (work_q == '0);
  assign Parity_Flag = hold & (^work_q);

endmodule

// File: tb/tb_logic_shift_unit.sv
// Directed and randomized bench for logic_shift_unit against a behavioural reference model.
module tb_logic_shift_unit;

  localparam int W = 16;

  logic          Clk;
  logic          RST;
  logic [W-1:0]  A, B;
  logic [2:0]    Logic_FUN;
  logic          In_Valid;
  logic          In_Ready;
  logic [W-1:0]  Logic_OUT;
  logic          Logic_Flag;
  logic          Out_Ready;
  logic          Zero_Flag;
  logic          Parity_Flag;

  int n_checks = 0;
  int n_pass   = 0;

  logic_shift_unit #(.WIDTH(W)) dut (
    .Clk         (Clk),
    .RST         (RST),
    .A           (A),
    .B           (B),
    .Logic_FUN   (Logic_FUN),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .Logic_OUT   (Logic_OUT),
    .Logic_Flag  (Logic_Flag),
    .Out_Ready   (Out_Ready),
    .Zero_Flag   (Zero_Flag),
    .Parity_Flag (Parity_Flag)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference result straight from the opcode table; rotation by shift-and-or.
  function automatic logic [W-1:0] ref_op(input logic [2:0] fun, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    int n;
    logic [W-1:0] r;
    n = int'(b) % W;
    case (fun)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~(a & b);
      3'd3:    r = ~(a | b);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      3'd6:    r = (n == 0) ? a : W'((a << n) | (a >> (W - n)));
      default: r = (n == 0) ? a : W'((a >> n) | (a << (W - n)));
    endcase
    return r;
  endfunction

  // Cycles spent busy between acceptance and result: the rotate count, else none.
  function automatic int busy_cycles(input logic [2:0] fun, input logic [W-1:0] b);
    return (fun >= 3'd6) ? (int'(b) % W) : 0;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] exp);
    check({tag, "/flag"}, Logic_Flag, 1);
    check({tag, "/out"}, Logic_OUT, exp);
    check({tag, "/zero"}, Zero_Flag, (exp == '0));
    check({tag, "/par"}, Parity_Flag, ^exp);
  endtask

  task automatic check_quiet(input string tag, input logic exp_rdy);
    check({tag, "/flag"}, Logic_Flag, 0);
    check({tag, "/out"}, Logic_OUT, 0);
    check({tag, "/zero"}, Zero_Flag, 0);
    check({tag, "/par"}, Parity_Flag, 0);
    check({tag, "/rdy"}, In_Ready, exp_rdy);
  endtask

  // One request from IDLE, stalled for 'stall' cycles in HOLD, then drained back to IDLE.
  task automatic do_op(input string tag, input logic [2:0] fun, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int stall);
    logic [W-1:0] exp;
    int lat;
    exp = ref_op(fun, a, b);
    lat = busy_cycles(fun, b);
    Logic_FUN = fun; A = a; B = b; In_Valid = 1'b1; Out_Ready = 1'b1;
    #1 check({tag, "/idle_rdy"}, In_Ready, 1);
    tick();
    In_Valid = 1'b0; A = W'($urandom); B = W'($urandom); Logic_FUN = 3'($urandom);
    for (int i = 0; i < lat; i++) begin
      #1 check_quiet({tag, "/rot"}, 1'b0);
      tick();
    end
    for (int s = 0; s <= stall; s++) begin
      Out_Ready = (s == stall);
      #1 check_result(tag, exp);
      check({tag, "/hold_rdy"}, In_Ready, Out_Ready);
      tick();
    end
    #1 check_quiet({tag, "/drain"}, 1'b1);
  endtask

  initial begin
    RST = 1'b0; A = '0; B = '0; Logic_FUN = '0; In_Valid = 1'b0; Out_Ready = 1'b1;
    #3 check_quiet("reset", 1'b1);
    tick();
    RST = 1'b1;
    tick();

    do_op("and", 3'd0, 16'hF0F0, 16'hFF00, 0);
    do_op("xor_zero", 3'd4, 16'h1234, 16'h1234, 0);
    do_op("rol3", 3'd6, 16'h8001, 16'h0003, 0);
    do_op("ror_n0", 3'd7, 16'h0001, 16'h0010, 0);

    // Backpressure for 4 cycles, then a NOR accepted on the draining edge with no bubble.
    Logic_FUN = 3'd0; A = 16'hA5A5; B = 16'h0FF0; In_Valid = 1'b1; Out_Ready = 1'b0;
    tick();
    In_Valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check_result("bp_hold", 16'h05A0);
      check("bp_rdy", In_Ready, 0);
      tick();
    end
    Logic_FUN = 3'd3; A = 16'h0000; B = 16'h0000; In_Valid = 1'b1; Out_Ready = 1'b1;
    #1 check("bp_release_rdy", In_Ready, 1);
    tick();
    In_Valid = 1'b0;
    #1 check_result("b2b_nor", 16'hFFFF);
    tick();
    #1 check_quiet("b2b_drain", 1'b1);

    // Reset in the middle of a 15-step rotate.
    Logic_FUN = 3'd7; A = 16'h8000; B = 16'h000F; In_Valid = 1'b1;
    tick();
    In_Valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_quiet("pre_rst_rot", 1'b0);
    RST = 1'b0;
    #1 check_quiet("async_rst", 1'b1);
    Logic_FUN = 3'd0; A = 16'h00FF; B = 16'h0F0F; In_Valid = 1'b1;
    tick();
    check_quiet("no_accept_in_rst", 1'b1);
    #2 RST = 1'b1;
    tick();
    In_Valid = 1'b0;
    #1 check_result("post_rst_and", 16'h000F);
    tick();
    #1 check_quiet("post_rst_drain", 1'b1);

    for (int t = 0; t < 60; t++) begin
      logic [2:0] f;
      f = 3'(t % 8);
      if (t >= 8) f = 3'($urandom);
      do_op($sformatf("rnd%0d", t), f, W'($urandom), W'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
